cmd_prefetch: RTL and testbench

Upstream feeder for the command queue. On a start pulse, streams a contiguous block of `cmd_t` words from a 1-cycle-latency command memory into the command FIFO that the issuer in `top` drains via `queue_cmd`/`queue_empty`. It honours FIFO backpressure without dropping or duplicating commands, and replaces the testbench-side `$readmemb` preload of the queue in system-level runs.

---
 rtl/cmd_prefetch_pkg.sv | 16 +
 rtl/cmd_skid_buf.sv | 38 +++
 rtl/cmd_prefetch.sv | 83 ++++++++
 tb/tb_cmd_prefetch.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cmd_prefetch_pkg.sv
// cmd_prefetch_pkg: shared command word type and prefetch FSM state encoding.
package cmd_prefetch_pkg;

    typedef struct packed {
        logic [7:0]  op;
        logic [23:0] arg;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } prefetch_state_t;

endpackage

// File: rtl/cmd_skid_buf.sv
// cmd_skid_buf: 2-entry FIFO of cmd_t; push and pop may occur in the same cycle.
module cmd_skid_buf
    import cmd_prefetch_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_push,
    input  cmd_t       i_data,
    input  logic       i_pop,
    output logic [1:0] o_count,
    output cmd_t       o_head
);

    cmd_t mem [2];
    logic wr_ptr;
    logic rd_ptr;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            o_count <= 2'd0;
        end else begin
            if (i_push) begin
                mem[wr_ptr] <= i_data;
                wr_ptr      <= !wr_ptr;
            end
            if (i_pop)
                rd_ptr <= !rd_ptr;
            o_count <= o_count + 2'(i_push) - 2'(i_pop);
        end
    end

    assign o_head = mem[rd_ptr];

endmodule

// File: rtl/cmd_prefetch.sv
// cmd_prefetch: streams a block of commands from 1-cycle-latency memory into the
// command FIFO, using credit-based flow control over a 2-entry skid buffer.
module cmd_prefetch
    import cmd_prefetch_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int CNT_W  = 18
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [CNT_W-1:0]  i_count,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  cmd_t              i_mem_rd_data,
    output logic              o_fifo_write,
    output cmd_t              o_fifo_data,
    input  logic              i_fifo_full,
    output logic [CNT_W-1:0]  o_written
);

    prefetch_state_t   state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  remaining;
    logic              in_flight;
    logic [1:0]        occ;
    logic [2:0]        credit;
    logic              drained;

    cmd_skid_buf u_buf (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_push  (in_flight),
        .i_data  (i_mem_rd_data),
        .i_pop   (o_fifo_write),
        .o_count (occ),
        .o_head  (o_fifo_data)
    );

    assign o_fifo_write = occ != 2'd0 && !i_fifo_full;
    // Slots already claimed by buffered or in-flight data, net of this cycle's push.
    assign credit       = {1'b0, occ} + 3'(in_flight) - 3'(o_fifo_write);
    assign o_mem_rd_en  = state == FETCH && remaining != '0 && credit < 3'd2;
    assign o_mem_addr   = addr;
    assign o_busy       = state != IDLE;
    assign o_done       = state == DONE;
    assign drained      = !in_flight && occ - 2'(o_fifo_write) == 2'd0;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            in_flight <= 1'b0;
            o_written <= '0;
        end else begin
            in_flight <= o_mem_rd_en;
            if (o_fifo_write)
                o_written <= o_written + CNT_W'(1);
            if (o_mem_rd_en) begin
                addr      <= addr + ADDR_W'(1);
                remaining <= remaining - CNT_W'(1);
            end
            case (state)
                IDLE: if (i_start) begin
                    addr      <= i_base_addr;
                    remaining <= i_count;
                    o_written <= '0;
                    state     <= i_count == '0 ? DONE : FETCH;
                end
                FETCH: if (o_mem_rd_en && remaining == CNT_W'(1))
                    state <= DRAIN;
                DRAIN: if (drained)
                    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_prefetch.sv
// tb_cmd_prefetch: directed checks of cmd_prefetch timing, ordering, backpressure and reset.
module tb_cmd_prefetch;
    import cmd_prefetch_pkg::cmd_t;

    localparam int CW = $bits(cmd_t);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          fifo_full = 1'b0;
    logic [17:0]   base_addr = '0;
    logic [17:0]   count = '0;
    logic          busy, done, rd_en, fifo_write;
    logic [17:0]   mem_addr, written;
    logic [CW-1:0] rd_data = '0;
    logic [CW-1:0] fifo_data;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cyc = -1;
    int          max_out = 0;
    int          rd_cyc[$];
    int          push_cyc[$];
    logic [17:0] rd_addr[$];
    logic [17:0] exp_addr = '0;

    cmd_prefetch #(.ADDR_W(18), .CNT_W(18)) dut (
        .i_clk         (clk),
        .i_rstn        (rst_n),
        .i_start       (start),
        .i_base_addr   (base_addr),
        .i_count       (count),
        .o_busy        (busy),
        .o_done        (done),
        .o_mem_rd_en   (rd_en),
        .o_mem_addr    (mem_addr),
        .i_mem_rd_data (rd_data),
        .o_fifo_write  (fifo_write),
        .o_fifo_data   (fifo_data),
        .i_fifo_full   (fifo_full),
        .o_written     (written)
    );

    function automatic logic [CW-1:0] cmd_of(input logic [17:0] a);
        return CW'({14'h2B7, a});
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rd_en) rd_data <= cmd_of(mem_addr);

    // Memory-side log and in-order scoreboard of every push
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) begin
                rd_cyc.push_back(cyc - start_cyc);
                rd_addr.push_back(mem_addr);
            end
            if (fifo_write) begin
                check("push_order", {fifo_full, fifo_data}, {1'b0, cmd_of(exp_addr)});
                exp_addr = exp_addr + 18'd1;
                push_cyc.push_back(cyc - start_cyc);
            end
            if (done)
                done_cyc = cyc - start_cyc;
            if (rd_addr.size() - push_cyc.size() > max_out)
                max_out = rd_addr.size() - push_cyc.size();
        end
    end

    task automatic clear_logs(input logic [17:0] base);
        rd_cyc.delete();
        rd_addr.delete();
        push_cyc.delete();
        exp_addr = base;
        done_cyc = -1;
        max_out = 0;
    endtask

    // mode: 0 never full, 1 full in cycles 4..9, 2 random full, 3 extra start in cycle 2
    task automatic run(input logic [17:0] base, input logic [17:0] n, input int mode, input int budget);
        int   rel;
        logic got;
        clear_logs(base);
        got = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = base;
        count = n;
        start_cyc = cyc;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk); #1;
            rel = cyc - start_cyc;
            start = mode == 3 && rel == 2;
            if (start) begin
                base_addr = 18'h999;
                count = 18'd1;
            end
            fifo_full = mode == 1 ? (rel >= 4 && rel <= 9) : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (done) got = 1'b1;
        end
        fifo_full = 1'b0;
        start = 1'b0;
        #2;
        check("done_seen", got, 1'b1);
    endtask

    initial begin
        int          n_before;
        int          rd_in_full;
        logic [17:0] a;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_addr", mem_addr, 18'd0);
        check("rst_fifo_write", fifo_write, 1'b0);
        check("rst_fifo_data", fifo_data, '0);
        check("rst_written", written, 18'd0);
        rst_n = 1'b1;

        run(18'h100, 18'd4, 0, 50);
        check("basic_rd_n", rd_cyc.size(), 4);
        check("basic_push_n", push_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("basic_rd_cyc", rd_cyc[i], i + 1);
            check("basic_rd_addr", rd_addr[i], 18'h100 + 18'(i));
            check("basic_push_cyc", push_cyc[i], i + 3);
        end
        check("basic_done_cyc", done_cyc, 7);
        check("basic_written", written, 18'd4);
        @(negedge clk);
        check("basic_idle_after", busy, 1'b0);

        run(18'h200, 18'd8, 1, 100);
        check("bp_push_n", push_cyc.size(), 8);
        check("bp_outstanding", max_out <= 2, 1'b1);
        rd_in_full = 0;
        foreach (rd_cyc[i]) if (rd_cyc[i] >= 4 && rd_cyc[i] <= 9) rd_in_full++;
        check("bp_no_reads_full", rd_in_full, 0);
        check("bp_done_after_last", done_cyc, push_cyc[push_cyc.size() - 1] + 1);
        check("bp_written", written, 18'd8);

        run(18'h3FFFE, 18'd4, 0, 50);
        check("wrap_rd_n", rd_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            a = 18'h3FFFE + 18'(i);
            check("wrap_addr", rd_addr[i], a);
        end
        check("wrap_push_n", push_cyc.size(), 4);

        run(18'h55, 18'd0, 0, 20);
        check("zero_done_cyc", done_cyc, 1);
        check("zero_rd_n", rd_cyc.size(), 0);
        check("zero_push_n", push_cyc.size(), 0);
        check("zero_written", written, 18'd0);

        run(18'h300, 18'd6, 3, 60);
        check("busy_start_push_n", push_cyc.size(), 6);
        check("busy_start_written", written, 18'd6);
        check("busy_start_last_rd", rd_addr[rd_addr.size() - 1], 18'h305);

        clear_logs(18'h400);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = 18'h400;
        count = 18'd16;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rd_en", rd_en, 1'b0);
        check("mid_rst_fifo_write", fifo_write, 1'b0);
        check("mid_rst_fifo_data", fifo_data, '0);
        check("mid_rst_written", written, 18'd0);
        check("mid_rst_addr", mem_addr, 18'd0);
        n_before = push_cyc.size();
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("mid_rst_no_push", push_cyc.size(), n_before);
        check("mid_rst_idle", busy, 1'b0);

        run(18'h500, 18'd2, 0, 50);
        check("post_rst_push_n", push_cyc.size(), 2);
        check("post_rst_done_cyc", done_cyc, 5);
        check("post_rst_written", written, 18'd2);

        run(18'h1000, 18'd1000, 2, 6000);
        check("rand_push_n", push_cyc.size(), 1000);
        check("rand_written", written, 18'd1000);
        check("rand_outstanding", max_out <= 2, 1'b1);
        check("rand_last_addr", exp_addr, 18'h1000 + 18'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
